voice_sequencer: RTL and testbench
==================================

Name: voice_sequencer

Overview:
- Per-sample scheduler for the synth core.
- On each sample-rate tick it steps the envelope datapath through voices 0..NUM_VOICES-1 using a start/ready handshake, then launches the mixer.
- It also owns the single shared multiplier and arbitrates it between the envelope and the mixer, routing start and ready pulses.
- Sits between the sample-rate divider and the envelope/mixer blocks.

Parameters:
- NUM_VOICES, 3, number of voices sequenced per sample (1..4).
- TIMEOUT_CYCLES, 255, max cycles to wait for any ready before aborting the sample.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- sample_tick_i  in  1  one-cycle strobe, start of sample period
- voice_idx_o  out  2  voice currently being processed (drives envelope voice_idx and register muxes)
- env_start_o  out  1  one-cycle start pulse to envelope
- env_ready_i  in  1  envelope done pulse
- mix_start_o  out  1  one-cycle start pulse to mixer
- mix_ready_i  in  1  mixer done pulse
- env_mult_req_i  in  1  envelope multiplier request pulse
- mix_mult_req_i  in  1  mixer multiplier request pulse
- env_mult_ready_o  out  1  multiplier done, routed to envelope
- mix_mult_ready_o  out  1  multiplier done, routed to mixer
- mult_start_o  out  1  start pulse to shared multiplier
- mult_sel_o  out  1  operand mux select: 0 = envelope, 1 = mixer
- mult_ready_i  in  1  multiplier done pulse
- sample_valid_o  out  1  one-cycle pulse, sample complete
- busy_o  out  1  high from accepted tick until DONE/ABORT exit
- overrun_o  out  1  sticky: tick arrived while busy
- timeout_o  out  1  sticky: a ready wait exceeded TIMEOUT_CYCLES
- clr_flags_i  in  1  clears overrun_o and timeout_o

Behaviour:
- Single clock clk_i; synchronous active-high reset rst_i. All state updates on posedge clk_i.
- Reset values: all outputs 0, state IDLE, voice counter 0, arbiter idle, pending flags 0.
- Sequencer FSM:
  - IDLE: on sample_tick_i -> START. Voice counter is 0.
  - START: env_start_o=1 for exactly this cycle -> WAIT_ENV. Wait counter cleared.
  - WAIT_ENV: on env_ready_i, if counter==NUM_VOICES-1 -> MIX_START, else counter++ and -> START.
  - MIX_START: mix_start_o=1 for one cycle -> MIX_WAIT.
  - MIX_WAIT: on mix_ready_i -> DONE.
  - DONE: sample_valid_o=1 for one cycle -> IDLE.
  - ABORT: entered from WAIT_ENV or MIX_WAIT when the wait counter reaches TIMEOUT_CYCLES. Sets timeout_o, drops pending multiplier requests, no sample_valid_o -> IDLE.
- Timing: voice_idx_o is stable from START through its WAIT_ENV exit. Minimum latency tick->sample_valid_o with zero-wait readies is 2*NUM_VOICES+3 cycles (9 for default).
- busy_o = (state != IDLE).
- Tick in any non-IDLE state: ignored, overrun_o set. Tick coincident with the DONE cycle also counts as overrun.
- Ready pulses received in states that do not wait for them are ignored.
- Multiplier arbiter (independent FSM, A_IDLE/A_BUSY):
  - Request pulses latch into pending bits. A request arriving while that requester's pending bit is set or it is granted is dropped.
  - In A_IDLE with any pending: grant envelope first (fixed priority). Set mult_sel_o, pulse mult_start_o the cycle after the grant decision, clear that pending bit, go to A_BUSY.
  - mult_sel_o is held stable through A_BUSY.
  - In A_BUSY: mult_ready_i is routed as a one-cycle pulse to env_mult_ready_o or mix_mult_ready_o per mult_sel_o -> A_IDLE.
  - Same-cycle mult_ready_i and new request: ready is routed; the request is latched and served next.
- clr_flags_i clears both sticky flags. Same-cycle set beats clear.
- Reset asserted mid-sample: everything returns to reset values on the next edge; no partial outputs.

Decomposition:
- Package synth_pkg holds:
  - seq_state_e (IDLE, START, WAIT_ENV, MIX_START, MIX_WAIT, DONE, ABORT)
  - arb_state_e
  - MULT_SEL_ENV/MULT_SEL_MIX constants
  - VOICE_IDX_W=2
- One sub-module: mult_arbiter (pending latches, grant, ready routing), instantiated once.
- Timeout counter stays inline.

Test Plan:
- Tick, envelope ready 2 cycles after each start, mixer ready 3 cycles after start -> voice_idx_o 0,1,2 with one env_start_o each; single sample_valid_o 14 cycles after tick; busy_o low after.
- Zero-wait readies -> sample_valid_o exactly 9 cycles after tick.
- Second tick during WAIT_ENV of voice 1 -> overrun_o=1, sequence completes normally, exactly one sample_valid_o; clr_flags_i -> overrun_o=0.
- env_ready_i withheld -> ABORT after 255 wait cycles, timeout_o=1, no sample_valid_o, next tick runs a full sequence.
- env_mult_req_i and mix_mult_req_i same cycle, mult_ready_i 4 cycles after each start -> envelope served first (mult_sel_o=0), env_mult_ready_o pulse, then mixer (mult_sel_o=1), mix_mult_ready_o pulse; two mult_start_o total.
- rst_i asserted during MIX_WAIT -> next cycle all outputs 0, state IDLE; stale mix_ready_i ignored.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth core sequencer.
// Imported by the sequencer interface, top and arbiter.
package synth_pkg;

  localparam int VOICE_IDX_W = 2;

  localparam logic MULT_SEL_ENV = 1'b0;
  localparam logic MULT_SEL_MIX = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ENV,
    MIX_START,
    MIX_WAIT,
    DONE,
    ABORT
  } seq_state_e;

  typedef enum logic {
    A_IDLE,
    A_BUSY
  } arb_state_e;

  typedef struct packed {
    logic env;
    logic mix;
  } mult_req_t;

endpackage

// File: rtl/voice_sequencer_if.sv
// Handshake bundle between the sequencer and the
// tick source, envelope, mixer and shared multiplier.
interface voice_sequencer_if;
  import synth_pkg::*;

  logic                   sample_tick_i;
  logic [VOICE_IDX_W-1:0] voice_idx_o;
  logic                   env_start_o;
  logic                   env_ready_i;
  logic                   mix_start_o;
  logic                   mix_ready_i;
  logic                   env_mult_req_i;
  logic                   mix_mult_req_i;
  logic                   env_mult_ready_o;
  logic                   mix_mult_ready_o;
  logic                   mult_start_o;
  logic                   mult_sel_o;
  logic                   mult_ready_i;
  logic                   sample_valid_o;
  logic                   busy_o;
  logic                   overrun_o;
  logic                   timeout_o;
  logic                   clr_flags_i;

  modport master (
    input  sample_tick_i,
    output voice_idx_o,
    output env_start_o,
    input  env_ready_i,
    output mix_start_o,
    input  mix_ready_i,
    input  env_mult_req_i,
    input  mix_mult_req_i,
    output env_mult_ready_o,
    output mix_mult_ready_o,
    output mult_start_o,
    output mult_sel_o,
    input  mult_ready_i,
    output sample_valid_o,
    output busy_o,
    output overrun_o,
    output timeout_o,
    input  clr_flags_i
  );

  modport slave (
    output sample_tick_i,
    input  voice_idx_o,
    input  env_start_o,
    output env_ready_i,
    input  mix_start_o,
    output mix_ready_i,
    output env_mult_req_i,
    output mix_mult_req_i,
    input  env_mult_ready_o,
    input  mix_mult_ready_o,
    input  mult_start_o,
    input  mult_sel_o,
    output mult_ready_i,
    input  sample_valid_o,
    input  busy_o,
    input  overrun_o,
    input  timeout_o,
    output clr_flags_i
  );

endinterface

// File: rtl/mult_arbiter.sv
// Shares one multiplier between envelope and mixer.
// Fixed priority to the envelope; ready routed by select.
module mult_arbiter
  import synth_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic env_req,
  input  logic mix_req,
  input  logic drop,
  input  logic mult_ready,
  output logic mult_start,
  output logic mult_sel,
  output logic env_ready,
  output logic mix_ready
);

  arb_state_e arb_q, arb_d;
  mult_req_t  pend_q, pend_d;
  logic       sel_q, sel_d;
  logic       start_q, start_d;
  logic       busy;
  logic       env_granted;
  logic       mix_granted;

  assign busy = (arb_q == A_BUSY);

  // A requester whose ready lands this cycle may re-request.
  assign env_granted = busy && !mult_ready &&
                       (sel_q == MULT_SEL_ENV);
  assign mix_granted = busy && !mult_ready &&
                       (sel_q == MULT_SEL_MIX);

  // Grant, pending-latch and release decisions.
  always_comb begin
    arb_d   = arb_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    unique case (arb_q)
      A_IDLE: begin
        if (pend_q.env) begin
          sel_d      = MULT_SEL_ENV;
          pend_d.env = 1'b0;
          start_d    = 1'b1;
          arb_d      = A_BUSY;
        end else if (pend_q.mix) begin
          sel_d      = MULT_SEL_MIX;
          pend_d.mix = 1'b0;
          start_d    = 1'b1;
          arb_d      = A_BUSY;
        end
      end
      A_BUSY: begin
        if (mult_ready) begin
          arb_d = A_IDLE;
        end
      end
      default: arb_d = A_IDLE;
    endcase
    if (env_req && !pend_q.env && !env_granted) begin
      pend_d.env = 1'b1;
    end
    if (mix_req && !pend_q.mix && !mix_granted) begin
      pend_d.mix = 1'b1;
    end
    if (drop) begin
      pend_d = '0;
    end
  end

  // Arbiter state, pending bits, select and start pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arb_q   <= A_IDLE;
      pend_q  <= '0;
      sel_q   <= MULT_SEL_ENV;
      start_q <= 1'b0;
    end else begin
      arb_q   <= arb_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      start_q <= start_d;
    end
  end

  assign mult_start = start_q;
  assign mult_sel   = sel_q;
  assign env_ready  = busy && mult_ready &&
                      (sel_q == MULT_SEL_ENV);
  assign mix_ready  = busy && mult_ready &&
                      (sel_q == MULT_SEL_MIX);

endmodule

// File: rtl/voice_sequencer.sv
// Per-sample scheduler: steps the envelope over all
// voices, then launches the mixer; owns the multiplier.
module voice_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_i,
  voice_sequencer_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [VOICE_IDX_W-1:0] LAST_VOICE =
    VOICE_IDX_W'(NUM_VOICES - 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [VOICE_IDX_W-1:0] voice_q, voice_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   overrun_q;
  logic                   timeout_q;
  logic                   set_timeout;
  logic                   set_overrun;

  assign set_overrun = bus.sample_tick_i &&
                       (state_q != IDLE);

  // Next state, voice counter and ready-wait counter.
  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    wait_d      = wait_q;
    set_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        voice_d = '0;
        if (bus.sample_tick_i) begin
          state_d = START;
        end
      end
      START: begin
        wait_d  = '0;
        state_d = WAIT_ENV;
      end
      WAIT_ENV: begin
        if (bus.env_ready_i) begin
          if (voice_q == LAST_VOICE) begin
            state_d = MIX_START;
          end else begin
            voice_d = voice_q + 1'b1;
            state_d = START;
          end
        end else if (wait_q == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_d     = ABORT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      MIX_START: begin
        wait_d  = '0;
        state_d = MIX_WAIT;
      end
      MIX_WAIT: begin
        if (bus.mix_ready_i) begin
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_d     = ABORT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        voice_d = '0;
        state_d = IDLE;
      end
      ABORT: begin
        voice_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      voice_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
      wait_q  <= wait_d;
    end
  end

  // Sticky error flags; a same-cycle set wins over clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      overrun_q <= set_overrun ||
                   (overrun_q && !bus.clr_flags_i);
      timeout_q <= set_timeout ||
                   (timeout_q && !bus.clr_flags_i);
    end
  end

  assign bus.voice_idx_o    = voice_q;
  assign bus.env_start_o    = (state_q == START);
  assign bus.mix_start_o    = (state_q == MIX_START);
  assign bus.sample_valid_o = (state_q == DONE);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.overrun_o      = overrun_q;
  assign bus.timeout_o      = timeout_q;

  mult_arbiter u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .env_req    (bus.env_mult_req_i),
    .mix_req    (bus.mix_mult_req_i),
    .drop       (state_q == ABORT),
    .mult_ready (bus.mult_ready_i),
    .mult_start (bus.mult_start_o),
    .mult_sel   (bus.mult_sel_o),
    .env_ready  (bus.env_mult_ready_o),
    .mix_ready  (bus.mix_mult_ready_o)
  );

endmodule

// File: tb/tb_voice_sequencer.sv
// Bench for voice_sequencer: responders plus an event log,
// checked against a cycle-arithmetic schedule model.
module tb_voice_sequencer;
  import synth_pkg::*;

  localparam int NV = 3;
  localparam int TO = 255;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  voice_sequencer_if vif();

  voice_sequencer #(
    .NUM_VOICES     (NV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (vif.master)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int env_dly [4];
  int mix_dly  = 1;
  int mult_dly = 4;
  bit env_hold = 1'b0;
  int env_due  = 0;
  int mix_due  = 0;
  int mult_due = 0;
  bit busy_prev = 1'b0;

  int tick_q[$];
  int st_c_q[$];
  int st_v_q[$];
  int mx_q[$];
  int val_q[$];
  int ms_c_q[$];
  int ms_s_q[$];
  int emr_q[$];
  int mmr_q[$];
  int erq_q[$];
  int mrq_q[$];
  int fall_q[$];

  // Responders drive readies at the falling edge, then log.
  always @(negedge clk_i) begin
    cyc = cyc + 1;
    vif.env_ready_i  = (cyc == env_due);
    vif.mix_ready_i  = (cyc == mix_due);
    vif.mult_ready_i = (cyc == mult_due);
    #1;
    if (vif.sample_tick_i) tick_q.push_back(cyc);
    if (vif.env_mult_req_i) erq_q.push_back(cyc);
    if (vif.mix_mult_req_i) mrq_q.push_back(cyc);
    if (vif.env_start_o) begin
      st_c_q.push_back(cyc);
      st_v_q.push_back(int'(vif.voice_idx_o));
      if (!env_hold)
        env_due = cyc + env_dly[vif.voice_idx_o];
    end
    if (vif.mix_start_o) begin
      mx_q.push_back(cyc);
      mix_due = cyc + mix_dly;
    end
    if (vif.sample_valid_o) val_q.push_back(cyc);
    if (vif.mult_start_o) begin
      ms_c_q.push_back(cyc);
      ms_s_q.push_back(int'(vif.mult_sel_o));
      mult_due = cyc + mult_dly;
    end
    if (vif.env_mult_ready_o) emr_q.push_back(cyc);
    if (vif.mix_mult_ready_o) mmr_q.push_back(cyc);
    if (!vif.busy_o && busy_prev) fall_q.push_back(cyc);
    busy_prev = vif.busy_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] outs();
    return {vif.voice_idx_o, vif.env_start_o,
            vif.mix_start_o, vif.env_mult_ready_o,
            vif.mix_mult_ready_o, vif.mult_start_o,
            vif.mult_sel_o, vif.sample_valid_o,
            vif.busy_o, vif.overrun_o, vif.timeout_o};
  endfunction

  // Start cycle of voice v (v == NV gives the mixer
  // start) for a tick seen in cycle t.
  function automatic int exp_start(int t, int v);
    int s = t + 1;
    for (int i = 0; i < v; i++) s += env_dly[i] + 1;
    return s;
  endfunction

  function automatic int exp_valid(int t);
    return exp_start(t, NV) + mix_dly + 1;
  endfunction

  task automatic clear_logs();
    tick_q.delete(); st_c_q.delete(); st_v_q.delete();
    mx_q.delete(); val_q.delete(); ms_c_q.delete();
    ms_s_q.delete(); emr_q.delete(); mmr_q.delete();
    erq_q.delete(); mrq_q.delete(); fall_q.delete();
  endtask

  task automatic pulse_tick();
    @(negedge clk_i);
    vif.sample_tick_i = 1'b1;
    @(negedge clk_i);
    vif.sample_tick_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_i);
    vif.clr_flags_i = 1'b1;
    @(negedge clk_i);
    vif.clr_flags_i = 1'b0;
    #2;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_i);
      #2;
      if (!vif.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2;
    checks++;
    if (outs() !== 12'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 000", outs());
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2;
    checks++;
    if (outs() !== 12'h0) begin
      errors++;
      $display("FAIL idle_outs: got %h want 000", outs());
    end
  endtask

  task automatic test_basic();
    bit ok;
    int t, v0;
    clear_logs();
    for (int i = 0; i < 4; i++) env_dly[i] = 2;
    mix_dly = 3;
    pulse_tick();
    wait_idle(100, ok);
    t = (tick_q.size() > 0) ? tick_q[0] : -1000;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_idle: busy stuck, want idle");
    end
    checks++;
    if (st_c_q.size() != NV) begin
      errors++;
      $display("FAIL basic_starts: got %0d want %0d",
               st_c_q.size(), NV);
    end
    for (int v = 0; v < NV && v < st_c_q.size(); v++) begin
      checks++;
      if (st_c_q[v] != t + 1 + 3 * v ||
          st_v_q[v] != v) begin
        errors++;
        $display("FAIL basic_voice%0d: got c%0d v%0d want c%0d",
                 v, st_c_q[v] - t, st_v_q[v], 1 + 3 * v);
      end
    end
    v0 = (val_q.size() > 0) ? val_q[0] - t : -1;
    checks++;
    if (val_q.size() != 1 || v0 != 14) begin
      errors++;
      $display("FAIL basic_valid: got n%0d at %0d want 1 at 14",
               val_q.size(), v0);
    end
    checks++;
    if (vif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %b want 0", vif.busy_o);
    end
  endtask

  task automatic test_zero_wait();
    bit ok;
    int t, v0, t2;
    clear_logs();
    for (int i = 0; i < 4; i++) env_dly[i] = 1;
    mix_dly = 1;
    pulse_tick();
    repeat (7) @(negedge clk_i);
    @(negedge clk_i);
    vif.sample_tick_i = 1'b1;
    @(negedge clk_i);
    vif.sample_tick_i = 1'b0;
    wait_idle(100, ok);
    repeat (3) @(negedge clk_i);
    #2;
    t  = (tick_q.size() > 0) ? tick_q[0] : -1000;
    t2 = (tick_q.size() > 1) ? tick_q[1] - t : -1;
    v0 = (val_q.size() > 0) ? val_q[0] - t : -1;
    checks++;
    if (val_q.size() != 1 || v0 != 2 * NV + 3) begin
      errors++;
      $display("FAIL zw_valid: got n%0d at %0d want 1 at %0d",
               val_q.size(), v0, 2 * NV + 3);
    end
    checks++;
    if (t2 != 2 * NV + 3) begin
      errors++;
      $display("FAIL zw_done_tick: got %0d want %0d",
               t2, 2 * NV + 3);
    end
    checks++;
    if (vif.overrun_o !== 1'b1 || st_c_q.size() != NV) begin
      errors++;
      $display("FAIL zw_done_overrun: got ov%b n%0d want 1 %0d",
               vif.overrun_o, st_c_q.size(), NV);
    end
    pulse_clr();
  endtask

  task automatic test_overrun();
    bit ok;
    int t, v0;
    clear_logs();
    for (int i = 0; i < 4; i++) env_dly[i] = 2;
    mix_dly = 3;
    pulse_tick();
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    vif.sample_tick_i = 1'b1;
    vif.clr_flags_i   = 1'b1;
    @(negedge clk_i);
    vif.sample_tick_i = 1'b0;
    vif.clr_flags_i   = 1'b0;
    #2;
    checks++;
    if (vif.overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL ov_set_beats_clr: got %b want 1",
               vif.overrun_o);
    end
    wait_idle(100, ok);
    repeat (2) @(negedge clk_i);
    #2;
    t  = (tick_q.size() > 0) ? tick_q[0] : -1000;
    v0 = (val_q.size() > 0) ? val_q[0] - t : -1;
    checks++;
    if (val_q.size() != 1 || v0 != 14) begin
      errors++;
      $display("FAIL ov_valid: got n%0d at %0d want 1 at 14",
               val_q.size(), v0);
    end
    checks++;
    if (vif.overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL ov_sticky: got %b want 1", vif.overrun_o);
    end
    pulse_clr();
    checks++;
    if (vif.overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL ov_clear: got %b want 0", vif.overrun_o);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t, f, v0;
    clear_logs();
    env_hold = 1'b1;
    pulse_tick();
    wait_idle(400, ok);
    #2;
    env_hold = 1'b0;
    t = (tick_q.size() > 0) ? tick_q[0] : -1000;
    f = (fall_q.size() > 0) ? fall_q[0] - t : -1;
    checks++;
    if (!ok || f != TO + 3) begin
      errors++;
      $display("FAIL to_abort: got idle at %0d want %0d",
               f, TO + 3);
    end
    checks++;
    if (vif.timeout_o !== 1'b1 || val_q.size() != 0) begin
      errors++;
      $display("FAIL to_flag: got to%b n%0d want 1 0",
               vif.timeout_o, val_q.size());
    end
    clear_logs();
    for (int i = 0; i < 4; i++) env_dly[i] = 1;
    mix_dly = 1;
    pulse_tick();
    wait_idle(100, ok);
    t  = (tick_q.size() > 0) ? tick_q[0] : -1000;
    v0 = (val_q.size() > 0) ? val_q[0] - t : -1;
    checks++;
    if (val_q.size() != 1 || v0 != 2 * NV + 3) begin
      errors++;
      $display("FAIL to_recover: got n%0d at %0d want 1 at %0d",
               val_q.size(), v0, 2 * NV + 3);
    end
    pulse_clr();
    checks++;
    if (vif.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got %b want 0", vif.timeout_o);
    end
  endtask

  task automatic test_mult_arb();
    int r, c0, c1;
    clear_logs();
    mult_dly = 4;
    @(negedge clk_i);
    vif.env_mult_req_i = 1'b1;
    vif.mix_mult_req_i = 1'b1;
    @(negedge clk_i);
    vif.env_mult_req_i = 1'b0;
    vif.mix_mult_req_i = 1'b0;
    repeat (16) @(negedge clk_i);
    r  = (erq_q.size() > 0) ? erq_q[0] : -1000;
    c0 = (ms_c_q.size() > 0) ? ms_c_q[0] - r : -1;
    c1 = (ms_c_q.size() > 1) ? ms_c_q[1] - r : -1;
    checks++;
    if (ms_c_q.size() != 2) begin
      errors++;
      $display("FAIL arb_nstart: got %0d want 2", ms_c_q.size());
    end
    checks++;
    if (c0 != 2 || ms_s_q.size() < 1 || ms_s_q[0] != 0) begin
      errors++;
      $display("FAIL arb_first_env: got c%0d want c2 sel0", c0);
    end
    checks++;
    if (c1 != 8 || ms_s_q.size() < 2 || ms_s_q[1] != 1) begin
      errors++;
      $display("FAIL arb_second_mix: got c%0d want c8 sel1", c1);
    end
    checks++;
    if (emr_q.size() != 1 || emr_q[0] - r != 6) begin
      errors++;
      $display("FAIL arb_env_ready: got n%0d want 1 at 6",
               emr_q.size());
    end
    checks++;
    if (mmr_q.size() != 1 || mmr_q[0] - r != 12) begin
      errors++;
      $display("FAIL arb_mix_ready: got n%0d want 1 at 12",
               mmr_q.size());
    end
    clear_logs();
    @(negedge clk_i);
    vif.env_mult_req_i = 1'b1;
    @(negedge clk_i);
    vif.env_mult_req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    @(negedge clk_i);
    vif.env_mult_req_i = 1'b1;
    @(negedge clk_i);
    vif.env_mult_req_i = 1'b0;
    repeat (14) @(negedge clk_i);
    r  = (erq_q.size() > 0) ? erq_q[0] : -1000;
    c1 = (ms_c_q.size() > 1) ? ms_c_q[1] - r : -1;
    checks++;
    if (c1 != 8 || emr_q.size() != 2) begin
      errors++;
      $display("FAIL arb_ready_req: got c%0d n%0d want c8 n2",
               c1, emr_q.size());
    end
    clear_logs();
    @(negedge clk_i);
    vif.mix_mult_req_i = 1'b1;
    @(negedge clk_i);
    vif.mix_mult_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    vif.mix_mult_req_i = 1'b1;
    @(negedge clk_i);
    vif.mix_mult_req_i = 1'b0;
    repeat (14) @(negedge clk_i);
    checks++;
    if (ms_c_q.size() != 1 || mmr_q.size() != 1) begin
      errors++;
      $display("FAIL arb_drop_dup: got n%0d want 1",
               ms_c_q.size());
    end
  endtask

  task automatic test_rand_mult();
    int r, who, want_rdy;
    for (int k = 0; k < 12; k++) begin
      clear_logs();
      who = int'($urandom_range(0, 1));
      mult_dly = int'($urandom_range(1, 6));
      @(negedge clk_i);
      if (who == 0) vif.env_mult_req_i = 1'b1;
      else vif.mix_mult_req_i = 1'b1;
      @(negedge clk_i);
      vif.env_mult_req_i = 1'b0;
      vif.mix_mult_req_i = 1'b0;
      repeat (mult_dly + 6) @(negedge clk_i);
      r = (who == 0) ?
          ((erq_q.size() > 0) ? erq_q[0] : -1000) :
          ((mrq_q.size() > 0) ? mrq_q[0] : -1000);
      want_rdy = r + 2 + mult_dly;
      checks++;
      if (ms_c_q.size() != 1 || ms_c_q[0] != r + 2 ||
          ms_s_q[0] != who) begin
        errors++;
        $display("FAIL rmult_start%0d: got n%0d want 1 sel%0d",
                 k, ms_c_q.size(), who);
      end
      checks++;
      if (who == 0 ?
          (emr_q.size() != 1 || emr_q[0] != want_rdy ||
           mmr_q.size() != 0) :
          (mmr_q.size() != 1 || mmr_q[0] != want_rdy ||
           emr_q.size() != 0)) begin
        errors++;
        $display("FAIL rmult_ready%0d: got e%0d m%0d want who%0d",
                 k, emr_q.size(), mmr_q.size(), who);
      end
    end
  endtask

  task automatic test_rand_samples();
    bit ok;
    int t, v0, m0;
    for (int k = 0; k < 15; k++) begin
      clear_logs();
      for (int i = 0; i < 4; i++)
        env_dly[i] = int'($urandom_range(1, 6));
      mix_dly = int'($urandom_range(1, 6));
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      pulse_tick();
      wait_idle(200, ok);
      t  = (tick_q.size() > 0) ? tick_q[0] : -1000;
      v0 = (val_q.size() > 0) ? val_q[0] : -1;
      m0 = (mx_q.size() > 0) ? mx_q[0] : -1;
      checks++;
      if (!ok || st_c_q.size() != NV) begin
        errors++;
        $display("FAIL rs_starts%0d: got %0d want %0d",
                 k, st_c_q.size(), NV);
      end
      for (int v = 0; v < NV && v < st_c_q.size(); v++) begin
        checks++;
        if (st_c_q[v] != exp_start(t, v) || st_v_q[v] != v) begin
          errors++;
          $display("FAIL rs_voice%0d_%0d: got c%0d want c%0d",
                   k, v, st_c_q[v] - t, exp_start(t, v) - t);
        end
      end
      checks++;
      if (m0 != exp_start(t, NV)) begin
        errors++;
        $display("FAIL rs_mix%0d: got %0d want %0d",
                 k, m0 - t, exp_start(t, NV) - t);
      end
      checks++;
      if (val_q.size() != 1 || v0 != exp_valid(t)) begin
        errors++;
        $display("FAIL rs_valid%0d: got %0d want %0d",
                 k, v0 - t, exp_valid(t) - t);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t, m0;
    clear_logs();
    for (int i = 0; i < 4; i++) env_dly[i] = 2;
    mix_dly = 5;
    pulse_tick();
    repeat (10) @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    checks++;
    if (outs() !== 12'h0) begin
      errors++;
      $display("FAIL rmid_outs: got %h want 000", outs());
    end
    t  = (tick_q.size() > 0) ? tick_q[0] : -1000;
    m0 = (mx_q.size() > 0) ? mx_q[0] - t : -1;
    checks++;
    if (m0 != 10) begin
      errors++;
      $display("FAIL rmid_in_mixwait: got %0d want 10", m0);
    end
    repeat (10) @(negedge clk_i);
    #2;
    checks++;
    if (val_q.size() != 0 || vif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stale: got n%0d busy%b want 0 0",
               val_q.size(), vif.busy_o);
    end
    clear_logs();
    mix_dly = 1;
    pulse_tick();
    wait_idle(100, ok);
    checks++;
    if (!ok || val_q.size() != 1) begin
      errors++;
      $display("FAIL rmid_recover: got n%0d want 1",
               val_q.size());
    end
  endtask

  initial begin
    vif.sample_tick_i  = 1'b0;
    vif.env_mult_req_i = 1'b0;
    vif.mix_mult_req_i = 1'b0;
    vif.clr_flags_i    = 1'b0;
    for (int i = 0; i < 4; i++) env_dly[i] = 1;
    test_reset();
    test_basic();
    test_zero_wait();
    test_overrun();
    test_timeout();
    test_mult_arb();
    test_rand_mult();
    test_rand_samples();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
